t_mux_buf: RTL and testbench

T_MUX_BUF -- requirements
Module: t_mux_buf

---
 rtl/t_mux_buf.sv | 90 +++++++++
 tb/tb_t_mux_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/t_mux_buf.sv
// Two-source input mux feeding a DEPTH-entry FIFO with registered-only backpressure.
// The head entry is presented one cycle after it is written; there is no fall-through.
module t_mux_buf #(
    parameter int unsigned A_W   = 4,
    parameter int unsigned D_W   = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic                       i_v,
    input  logic                       i_sel,
    input  logic [A_W-1:0]             i0_addr,
    input  logic [A_W-1:0]             i1_addr,
    input  logic [D_W-1:0]             i0_data,
    input  logic [D_W-1:0]             i1_data,
    output logic                       i_bp,
    output logic                       o_v,
    output logic [A_W-1:0]             o_addr,
    output logic [D_W-1:0]             o_data,
    input  logic                       o_bp,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam logic [OW-1:0] Full = OW'(DEPTH);

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic [A_W-1:0] mem_addr [DEPTH];
    logic [D_W-1:0] mem_data [DEPTH];

    logic           push, pop;
    logic [A_W-1:0] sel_addr;
    logic [D_W-1:0] sel_data;

    assign sel_addr = i_sel ? i1_addr : i0_addr;
    assign sel_data = i_sel ? i1_data : i0_data;

    // Backpressure depends only on registered occupancy and ce.
    assign i_bp = ~ce | (occ_q == Full);
    assign o_v  = ce & (occ_q != '0);

    assign push = ce & i_v & ~i_bp;
    assign pop  = ce & o_v & ~o_bp;

    assign o_addr = o_v ? mem_addr[rd_ptr_q] : '0;
    assign o_data = o_v ? mem_data[rd_ptr_q] : '0;
    assign occ    = occ_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is not reset; it is only visible once occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_addr[wr_ptr_q] <= sel_addr;
            mem_data[wr_ptr_q] <= sel_data;
        end
    end

endmodule

// File: tb/tb_t_mux_buf.sv
// Scoreboard bench for t_mux_buf: accepted pushes are queued, a monitor checks each pop.
module tb_t_mux_buf;

    localparam int A_W   = 4;
    localparam int D_W   = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n, ce, i_v, i_sel, o_bp;
    logic [A_W-1:0]   i0_addr, i1_addr, o_addr;
    logic [D_W-1:0]   i0_data, i1_data, o_data;
    logic             i_bp, o_v;
    logic [$clog2(DEPTH):0] occ;

    logic [A_W+D_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t_mux_buf #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .i_v     (i_v),
        .i_sel   (i_sel),
        .i0_addr (i0_addr),
        .i1_addr (i1_addr),
        .i0_data (i0_data),
        .i1_data (i1_data),
        .i_bp    (i_bp),
        .o_v     (o_v),
        .o_addr  (o_addr),
        .o_data  (o_data),
        .o_bp    (o_bp),
        .occ     (occ)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record words the bench expects to be accepted this cycle.
    always @(negedge clk) begin
        if (rst_n && ce && i_v && !i_bp) begin
            exp_q.push_back(i_sel ? {i1_addr, i1_data} : {i0_addr, i0_data});
        end
    end

    // Monitor: every pop must match the oldest outstanding word.
    always @(negedge clk) begin
        if (rst_n && o_v && !o_bp) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_empty_sb: got addr 0x%0h data 0x%0h expected no word",
                         o_addr, o_data);
            end else begin
                chk("pop_word", {32'd0, o_addr, o_data}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic put(input logic sel, input logic [A_W-1:0] a, input logic [D_W-1:0] d);
        i_v   = 1'b1;
        i_sel = sel;
        if (sel) begin
            i1_addr = a;
            i1_data = d;
            i0_addr = ~a;
            i0_data = ~d;
        end else begin
            i0_addr = a;
            i0_data = d;
            i1_addr = ~a;
            i1_data = ~d;
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        i_v  = 1'b0;
        o_bp = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            sample();
            if (occ == 0) done = 1'b1;
            else step();
        end
        chk("drain_occ", {59'd0, occ}, 64'd0);
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ce = 1'b1; i_v = 1'b0; i_sel = 1'b0; o_bp = 1'b0;
        i0_addr = '0; i1_addr = '0; i0_data = '0; i1_data = '0;
        step(); step();
        rst_n = 1'b1;
        sample();
        chk("rst_o_v", {63'd0, o_v}, 64'd0);
        chk("rst_o_addr", {60'd0, o_addr}, 64'd0);
        chk("rst_o_data", {32'd0, o_data}, 64'd0);
        chk("rst_i_bp", {63'd0, i_bp}, 64'd0);
        chk("rst_occ", {59'd0, occ}, 64'd0);
        step();

        // Single word through an empty buffer.
        put(1'b1, 4'd5, 32'hA5A5);
        sample();
        chk("single_pre_o_v", {63'd0, o_v}, 64'd0);
        step();
        i_v = 1'b0;
        sample();
        chk("single_o_v", {63'd0, o_v}, 64'd1);
        chk("single_o_addr", {60'd0, o_addr}, 64'd5);
        chk("single_o_data", {32'd0, o_data}, 64'hA5A5);
        step();
        sample();
        chk("single_after_o_v", {63'd0, o_v}, 64'd0);
        chk("single_after_occ", {59'd0, occ}, 64'd0);
        step();

        // Fill to full, fifth word refused, then drain in order.
        o_bp = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            put(1'b0, 4'(k), 32'(k));
            step();
        end
        put(1'b0, 4'd5, 32'd5);
        sample();
        chk("fill_occ", {59'd0, occ}, 64'd4);
        chk("fill_i_bp", {63'd0, i_bp}, 64'd1);
        step();
        sample();
        chk("fill_refused_occ", {59'd0, occ}, 64'd4);
        i_v = 1'b0;
        step();
        drain();

        // Full with pop and push offered together.
        o_bp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            put(k[0], 4'(10 + k), 32'h100 + 32'(k));
            step();
        end
        put(1'b0, 4'd14, 32'h104);
        o_bp = 1'b0;
        sample();
        chk("full_pop_i_bp", {63'd0, i_bp}, 64'd1);
        chk("full_pop_occ", {59'd0, occ}, 64'd4);
        step();
        sample();
        chk("after_full_occ", {59'd0, occ}, 64'd3);
        chk("after_full_i_bp", {63'd0, i_bp}, 64'd0);
        step();
        i_v = 1'b0;
        sample();
        chk("push_pop_occ", {59'd0, occ}, 64'd3);
        step();
        drain();

        // Wrap-around with alternating select and random backpressure.
        for (int j = 0; j < 10; j++) begin
            bit taken = 1'b0;
            put(j[0], 4'(j + 3), 32'hBEEF0000 + 32'(j));
            for (int r = 0; r < 50 && !taken; r++) begin
                o_bp = 1'($urandom_range(0, 1));
                sample();
                checks++;
                if (occ > DEPTH) begin
                    errors++;
                    $display("FAIL wrap_occ_bound: got %0d expected <= %0d", occ, DEPTH);
                end
                taken = !i_bp;
                step();
            end
            if (!taken) chk("wrap_accept", 64'd0, 64'd1);
        end
        drain();

        // Clock-enable gating freezes state.
        o_bp = 1'b1;
        put(1'b0, 4'd2, 32'h20); step();
        put(1'b1, 4'd3, 32'h21); step();
        o_bp = 1'b0;
        ce = 1'b0;
        put(1'b0, 4'd9, 32'h99);
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("ce_o_v", {63'd0, o_v}, 64'd0);
            chk("ce_i_bp", {63'd0, i_bp}, 64'd1);
            chk("ce_occ", {59'd0, occ}, 64'd2);
            step();
        end
        ce = 1'b1;
        i_v = 1'b0;
        o_bp = 1'b1;
        sample();
        chk("ce_head_addr", {60'd0, o_addr}, 64'd2);
        chk("ce_head_data", {32'd0, o_data}, 64'h20);
        step();
        drain();

        // Reset mid-operation discards stored words.
        o_bp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            put(1'b0, 4'(k + 1), 32'h30 + 32'(k));
            step();
        end
        i_v = 1'b0;
        sample();
        chk("pre_rst_occ", {59'd0, occ}, 64'd3);
        rst_n = 1'b0;
        sample();
        exp_q.delete();
        step();
        rst_n = 1'b1;
        o_bp = 1'b0;
        sample();
        chk("mid_rst_occ", {59'd0, occ}, 64'd0);
        chk("mid_rst_o_v", {63'd0, o_v}, 64'd0);
        chk("mid_rst_o_data", {32'd0, o_data}, 64'd0);
        step();
        put(1'b1, 4'd7, 32'h77);
        step();
        i_v = 1'b0;
        sample();
        chk("post_rst_o_v", {63'd0, o_v}, 64'd1);
        chk("post_rst_o_data", {32'd0, o_data}, 64'h77);
        step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
